instr_fetch: RTL and testbench

Instruction fetch stage sitting directly upstream of the decoder. Owns the program counter, fetches one 32-bit instruction word per request/acknowledge handshake from the memory/bus side, and presents it to the decoder as `ir` with a one-cycle `cs` strobe. It then tracks the decoder's `ready1` busy/done handshake and advances the PC sequentially or to a branch target supplied by the FCU.

---
 rtl/mp_pkg.sv | 14 +
 rtl/instr_fetch_pc_reg.sv | 46 ++++
 rtl/instr_fetch.sv | 88 ++++++++
 tb/tb_instr_fetch.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mp_pkg.sv
// Types and constants shared by the fetch stage and the blocks around it.
package mp_pkg;

  localparam int IR_W       = 32;
  localparam int ADDR_W_DEF = 16;

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter with sequential increment (silent wrap) and a redirect
// latch that remembers the most recent branch target until the PC update.
module pc_reg
  import mp_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br_sample,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              update,
  output logic [ADDR_W-1:0] pc,
  output logic              br_pending
);

  logic [ADDR_W-1:0] target_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      br_pending <= 1'b0;
      target_q   <= '0;
    end else begin
      if (br_sample) begin
        target_q <= br_target;
      end
      // A redirect seen in the completing cycle wins over an older one.
      if (update) begin
        if (br_sample) begin
          pc <= br_target;
        end else if (br_pending) begin
          pc <= target_q;
        end else begin
          pc <= pc + PC_STEP;
        end
        br_pending <= 1'b0;
      end else if (br_sample) begin
        br_pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: one memory read per instruction, a single-cycle cs strobe to
// the decoder, then waits for the decoder busy/done pulse before moving the PC.
module instr_fetch
  import mp_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [IR_W-1:0]   mem_rdata,
  output logic [IR_W-1:0]   ir,
  output logic              cs,
  input  logic              dec_ready,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] pc,
  output fetch_state_e      fsm_state
);

  // Memory handshake: mem_req is held from assertion until the cycle mem_ack
  // is seen; mem_ack without mem_req, or outside FETCH, has no effect.
  fetch_state_e state;
  logic         br_sample;
  logic         pc_update;
  logic         br_pending;

  assign br_sample = br_taken && ((state == WAIT_BUSY) || (state == WAIT_DONE));
  assign pc_update = (state == WAIT_DONE) && dec_ready;

  pc_reg #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC),
    .PC_STEP (PC_STEP)
  ) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .br_sample (br_sample),
    .br_target (br_target),
    .update    (pc_update),
    .pc        (pc),
    .br_pending(br_pending)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      mem_req <= 1'b0;
      ir      <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_req && mem_ack) begin
            ir      <= mem_rdata;
            mem_req <= 1'b0;
            state   <= ISSUE;
          end else if (run) begin
            mem_req <= 1'b1;
          end
        end
        ISSUE: state <= WAIT_BUSY;
        WAIT_BUSY: begin
          if (!dec_ready) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          // Raising the request on entry keeps the minimum loop at 4 cycles.
          if (dec_ready) begin
            state   <= FETCH;
            mem_req <= run;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign cs        = (state == ISSUE);
  assign mem_addr  = pc;
  assign fsm_state = state;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: transaction-level PC model plus a queue of fetched
// words, driven by directed steps followed by randomized instructions.
module tb_instr_fetch;
  import mp_pkg::*;

  localparam logic [15:0] RST_PC = 16'h0010;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] ir;
  logic        cs;
  logic        dec_ready;
  logic        br_taken;
  logic [15:0] br_target;
  logic [15:0] pc;
  fetch_state_e fsm_state;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [15:0] exp_pc;
  logic [31:0] exp_q[$];

  instr_fetch #(
    .ADDR_W  (16),
    .RESET_PC(RST_PC),
    .PC_STEP (16'd1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .ir       (ir),
    .cs       (cs),
    .dec_ready(dec_ready),
    .br_taken (br_taken),
    .br_target(br_target),
    .pc       (pc),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (mem_req !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("req_wait", {31'd0, mem_req}, 32'd1);
  endtask

  // One instruction: fetch with ack_dly wait states, decoder busy for 'busy'
  // cycles, optional redirect at offset br_cyc (0 = WAIT_BUSY, busy = done cycle).
  task automatic do_instr(input int ack_dly, input int busy, input int br_cyc,
                          input logic [15:0] tgt, input bit drop_run, input bit br_issue);
    logic [31:0] d;
    wait_req();
    check("mem_addr", {16'd0, mem_addr}, {16'd0, exp_pc});
    check("pc", {16'd0, pc}, {16'd0, exp_pc});
    if (drop_run) run = 1'b0;
    br_taken  = 1'($urandom_range(0, 1));
    br_target = 16'($urandom);
    for (int k = 0; k < ack_dly; k++) begin
      mem_ack = 1'b0;
      tick();
      check("req_held", {31'd0, mem_req}, 32'd1);
      check("cs_fetch", {31'd0, cs}, 32'd0);
    end
    d         = $urandom;
    mem_ack   = 1'b1;
    mem_rdata = d;
    exp_q.push_back(d);
    tick();
    mem_ack   = 1'b0;
    run       = 1'b1;
    br_taken  = br_issue;
    br_target = 16'($urandom);
    check("cs_issue", {31'd0, cs}, 32'd1);
    check("state_issue", {30'd0, fsm_state}, {30'd0, ISSUE});
    check("req_drop", {31'd0, mem_req}, 32'd0);
    check("ir", ir, exp_q.pop_front());
    tick();
    for (int j = 0; j <= busy; j++) begin
      dec_ready = (j == busy);
      br_taken  = (j == br_cyc);
      br_target = (j == br_cyc) ? tgt : 16'($urandom);
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      check("cs_low", {31'd0, cs}, 32'd0);
      check("ir_stable", ir, d);
      check("no_req", {31'd0, mem_req}, 32'd0);
      tick();
    end
    br_taken = 1'b0;
    mem_ack  = 1'b0;
    exp_pc   = (br_cyc >= 0) ? tgt : exp_pc + 16'd1;
    check("loop_req", {31'd0, mem_req}, 32'd1);
    check("next_addr", {16'd0, mem_addr}, {16'd0, exp_pc});
    check("ir_hold", ir, d);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    dec_ready = 1'b1; br_taken = 1'b0; br_target = '0;
    exp_pc = RST_PC;
    tick();
    tick();
    check("rst_pc", {16'd0, pc}, {16'd0, RST_PC});
    check("rst_ir", ir, 32'd0);
    check("rst_cs", {31'd0, cs}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_state", {30'd0, fsm_state}, {30'd0, FETCH});
    rst = 1'b0;

    // Idle with run low.
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_req", {31'd0, mem_req}, 32'd0);
      check("idle_cs", {31'd0, cs}, 32'd0);
      check("idle_pc", {16'd0, pc}, {16'd0, RST_PC});
    end

    // Minimum 4-cycle loops: 0x0010, 0x0011, 0x0012.
    run = 1'b1;
    for (int i = 0; i < 3; i++) do_instr(0, 1, -1, 16'h0, 1'b0, 1'b0);

    // Slow memory with run dropped during the wait.
    do_instr(3, 1, -1, 16'h0, 1'b1, 1'b0);

    // Redirect seen in WAIT_BUSY, then coincident with dec_ready rising.
    do_instr(0, 3, 0, 16'h0200, 1'b0, 1'b0);
    do_instr(1, 3, 3, 16'h0200, 1'b0, 1'b0);

    // Redirect in ISSUE is ignored; pending flag must not linger.
    do_instr(0, 1, -1, 16'h0, 1'b0, 1'b1);
    do_instr(0, 2, -1, 16'h0, 1'b0, 1'b0);

    // Wrap from 0xFFFF to 0x0000.
    do_instr(0, 2, 1, 16'hFFFF, 1'b0, 1'b0);
    do_instr(0, 1, -1, 16'h0, 1'b0, 1'b0);
    do_instr(0, 1, -1, 16'h0, 1'b0, 1'b0);

    // Reset with a request outstanding, then a late ack.
    wait_req();
    rst = 1'b1;
    tick();
    check("mid_rst_req", {31'd0, mem_req}, 32'd0);
    check("mid_rst_cs", {31'd0, cs}, 32'd0);
    check("mid_rst_pc", {16'd0, pc}, {16'd0, RST_PC});
    check("mid_rst_ir", ir, 32'd0);
    rst = 1'b0; run = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    check("late_ack_cs", {31'd0, cs}, 32'd0);
    check("late_ack_req", {31'd0, mem_req}, 32'd0);
    mem_ack = 1'b0;
    tick();
    check("late_ack_cs2", {31'd0, cs}, 32'd0);
    check("late_ack_ir", ir, 32'd0);
    exp_pc = RST_PC;
    run = 1'b1;

    // Randomized instruction stream.
    for (int i = 0; i < 40; i++) begin
      int ack_dly, busy, br_cyc;
      ack_dly = int'($urandom_range(0, 3));
      busy    = int'($urandom_range(1, 4));
      br_cyc  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, busy)) : -1;
      do_instr(ack_dly, busy, br_cyc, 16'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
